// File: rtl/adj_clock_divider_multi.sv
// Multi-channel adjustable clock divider: each channel emits a 50% duty divided clock
// and a rising-edge tick; reloaded divisors take effect only at half-period boundaries.
module adj_clock_divider_multi #(
    parameter int CHANNELS    = 4,
    parameter int DIV_WIDTH   = 16,
    parameter int DEFAULT_DIV = 1023
) (
    input  logic                                                ClkInput,
    input  logic                                                Reset,
    input  logic [CHANNELS-1:0]                                 Enable,
    input  logic                                                CfgValid,
    output logic                                                CfgReady,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] CfgChannel,
    input  logic [DIV_WIDTH-1:0]                                CfgDiv,
    input  logic                                                SyncAll,
    output logic [CHANNELS-1:0]                                 ClkOutput,
    output logic [CHANNELS-1:0]                                 TickOutput,
    output logic [CHANNELS-1:0]                                 CfgPending
);
    localparam int CH_WIDTH = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [DIV_WIDTH-1:0] RESET_DIV = DIV_WIDTH'(DEFAULT_DIV);

    logic [CHANNELS-1:0] pendVec_s;
    logic [CHANNELS-1:0] cfgHit_s;
    logic                selPend_s;
    logic                accept_s;

    // Pending flag of the addressed channel; an out-of-range index matches no channel
    always_comb begin
        selPend_s = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            selPend_s = selPend_s | (pendVec_s[i] & (CfgChannel == CH_WIDTH'(i)));
        end
    end

    assign CfgReady   = ~Reset & ~selPend_s;
    assign accept_s   = CfgValid & CfgReady;
    assign CfgPending = pendVec_s;

    // One-hot decode of an accepted write; out-of-range writes hit nothing and are dropped
    always_comb begin
        cfgHit_s = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cfgHit_s[i] = accept_s & (CfgChannel == CH_WIDTH'(i));
        end
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : gChan
        logic [DIV_WIDTH-1:0] cnt_r;
        logic [DIV_WIDTH-1:0] act_r;
        logic [DIV_WIDTH-1:0] shd_r;
        logic                 pend_r;
        logic                 clk_r;
        logic                 tick_r;
        logic                 boundary_s;

        // >= rather than == keeps the counter from ever wrapping past the active divisor
        assign boundary_s = (cnt_r >= act_r);

        // Counter, output toggle and shadow-to-active hand-over for one channel
        always_ff @(posedge ClkInput) begin
            if (Reset) begin
                cnt_r  <= '0;
                act_r  <= RESET_DIV;
                shd_r  <= RESET_DIV;
                pend_r <= 1'b0;
                clk_r  <= 1'b0;
                tick_r <= 1'b0;
            end else begin
                if (SyncAll) begin
                    cnt_r  <= '0;
                    clk_r  <= 1'b0;
                    tick_r <= 1'b0;
                    if (pend_r) begin
                        act_r <= shd_r;
                    end
                end else if (Enable[ch]) begin
                    if (boundary_s) begin
                        cnt_r  <= '0;
                        clk_r  <= ~clk_r;
                        tick_r <= ~clk_r;
                        if (pend_r) begin
                            act_r <= shd_r;
                        end
                    end else begin
                        cnt_r  <= cnt_r + DIV_WIDTH'(1);
                        tick_r <= 1'b0;
                    end
                end else begin
                    // A stopped channel has no boundary to wait for, so take the new divisor now
                    tick_r <= 1'b0;
                    if (pend_r) begin
                        act_r <= shd_r;
                        cnt_r <= '0;
                    end
                end

                // A write in the same cycle as an apply lands after the old value is consumed
                if (cfgHit_s[ch]) begin
                    shd_r  <= CfgDiv;
                    pend_r <= 1'b1;
                end else if (SyncAll || !Enable[ch] || boundary_s) begin
                    pend_r <= 1'b0;
                end
            end
        end

        assign ClkOutput[ch]  = clk_r;
        assign TickOutput[ch] = tick_r;
        assign pendVec_s[ch]  = pend_r;
    end

endmodule
